// File: rtl/adder_pkg.sv
// Shared defaults and operation encoding for the pipelined add/subtract unit.
package adder_pkg;
  localparam int ADDER_WIDTH  = 32;
  localparam int ADDER_STAGES = 2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/adder_seg.sv
// Combinational segment adder: one carry segment of the pipelined adder.
module adder_seg #(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           msb_cin
);
  logic [SEG:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
  assign sum  = full[SEG-1:0];
  assign cout = full[SEG];
  // Carry into the MSB, recovered from the MSB sum bit; works for SEG=1 too.
  assign msb_cin = a[SEG-1] ^ b[SEG-1] ^ full[SEG-1];
endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract, one carry segment per stage, valid/ready on both sides.
// Status flags (cout, ovf, zero) are built only when PIPE_ADDER_FLAGS_EN is defined.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDER_WIDTH,
  parameter int STAGES = ADDER_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int SEG = WIDTH / STAGES;

  logic             stall;
  logic [WIDTH-1:0] b_eff;

  // The whole pipe moves in lockstep: either every stage advances or all hold.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign b_eff    = (sub == OP_SUB) ? ~in2 : in2;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO  = gi * SEG;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]    a_cur;
    logic [REM-1:0]    b_cur;
    logic              cin_cur;
    logic              valid_cur;
    logic [SEG-1:0]    seg_sum;
    logic              seg_cout;
    logic              seg_msb_cin;
    logic [LO+SEG-1:0] res_next;
    logic [LO+SEG-1:0] res_reg;
    logic              valid_reg;

    if (gi == 0) begin : g_head
      assign a_cur     = in1;
      assign b_cur     = b_eff;
      assign cin_cur   = sub;
      assign valid_cur = in_valid;
      assign res_next  = seg_sum;
    end else begin : g_body
      assign a_cur     = g_stage[gi-1].g_fwd.a_reg;
      assign b_cur     = g_stage[gi-1].g_fwd.b_reg;
      assign cin_cur   = g_stage[gi-1].g_fwd.carry_reg;
      assign valid_cur = g_stage[gi-1].valid_reg;
      assign res_next  = {seg_sum, g_stage[gi-1].res_reg};
    end

    adder_seg #(.SEG(SEG)) u_seg (
      .a       (a_cur[SEG-1:0]),
      .b       (b_cur[SEG-1:0]),
      .cin     (cin_cur),
      .sum     (seg_sum),
      .cout    (seg_cout),
      .msb_cin (seg_msb_cin)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg <= 1'b0;
        res_reg   <= '0;
      end else if (!stall) begin
        valid_reg <= valid_cur;
        res_reg   <= res_next;
      end
    end

    if (gi < STAGES - 1) begin : g_fwd
      // Only the operand segments still to be added travel onward.
      logic [REM-SEG-1:0] a_reg;
      logic [REM-SEG-1:0] b_reg;
      logic               carry_reg;
      logic               msb_unused;

      assign msb_unused = seg_msb_cin;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_reg     <= '0;
          b_reg     <= '0;
          carry_reg <= 1'b0;
        end else if (!stall) begin
          a_reg     <= a_cur[REM-1:SEG];
          b_reg     <= b_cur[REM-1:SEG];
          carry_reg <= seg_cout;
        end
      end
    end else begin : g_tail
      assign out_valid = valid_reg;
      assign out       = res_reg;
`ifdef PIPE_ADDER_FLAGS_EN
      logic cout_reg;
      logic ovf_reg;
      logic zero_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cout_reg <= 1'b0;
          ovf_reg  <= 1'b0;
          zero_reg <= 1'b0;
        end else if (!stall) begin
          cout_reg <= seg_cout;
          ovf_reg  <= seg_cout ^ seg_msb_cin;
          zero_reg <= (res_next == '0);
        end
      end

      assign cout = cout_reg;
      assign ovf  = ovf_reg;
      assign zero = zero_reg;
`else
      logic flags_unused;

      assign flags_unused = seg_cout ^ seg_msb_cin;
      assign cout = 1'b0;
      assign ovf  = 1'b0;
      assign zero = 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder: a 32/2 instance and a 64/4 instance.
module tb_pipe_adder;
`ifdef PIPE_ADDER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] in1, in2, out;

  logic        w_in_valid, w_in_ready, w_sub, w_out_valid, w_out_ready, w_cout, w_ovf, w_zero;
  logic [63:0] w_in1, w_in2, w_out;

  int n_cmp = 0;
  int n_bad = 0;
  bit fm;

  pipe_adder #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .cout(cout), .ovf(ovf), .zero(zero)
  );

  pipe_adder #(.WIDTH(64), .STAGES(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in1(w_in1), .in2(w_in2), .sub(w_sub), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out(w_out), .cout(w_cout), .ovf(w_ovf), .zero(w_zero)
  );

  // Returns {cout, ovf, zero, out} with flags masked to the build.
  function automatic logic [34:0] model32(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] bb;
    logic [32:0] r;
    logic        o;
    bb = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {32'd0, s};
    o  = (a[31] == bb[31]) && (r[31] != a[31]);
    return {r[32] & fm, o & fm, (r[31:0] == 32'd0) & fm, r[31:0]};
  endfunction

  function automatic logic [66:0] model64(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic [63:0] bb;
    logic [64:0] r;
    logic        o;
    bb = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {64'd0, s};
    o  = (a[63] == bb[63]) && (r[63] != a[63]);
    return {r[64] & fm, o & fm, (r[63:0] == 64'd0) & fm, r[63:0]};
  endfunction

  task automatic test_reset();
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_hs32 out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    n_cmp++;
    if ({cout, ovf, zero, out} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_data32 got %h required 0", {cout, ovf, zero, out});
    end
    n_cmp++;
    if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1 || {w_cout, w_ovf, w_zero, w_out} !== 67'd0) begin
      n_bad++;
      $display("FAIL reset_64 out_valid=%b in_ready=%b data=%h required 0/1/0",
               w_out_valid, w_in_ready, {w_cout, w_ovf, w_zero, w_out});
    end
    $display("reset: out_valid=%b in_ready=%b out=%h", out_valid, in_ready, out);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] r;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  task automatic test_arith();
    vec_t tv [6];
    tv[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    tv[1] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tv[2] = '{32'h00000007, 32'h00000007, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tv[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tv[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tv[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in1 = tv[i].a; in2 = tv[i].b; sub = tv[i].s; in_valid = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL arith%0d_early out_valid=%b required 0", i, out_valid);
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out !== tv[i].r) begin
        n_bad++;
        $display("FAIL arith%0d_out valid=%b out=%h required 1/%h", i, out_valid, out, tv[i].r);
      end
      n_cmp++;
      if ({cout, ovf, zero} !== {tv[i].c & fm, tv[i].o & fm, tv[i].z & fm}) begin
        n_bad++;
        $display("FAIL arith%0d_flags c/o/z=%b%b%b required %b%b%b", i, cout, ovf, zero,
                 tv[i].c & fm, tv[i].o & fm, tv[i].z & fm);
      end
      $display("arith%0d: %h %s %h -> %h c=%b o=%b z=%b", i, tv[i].a, tv[i].s ? "-" : "+",
               tv[i].b, out, cout, ovf, zero);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [4] = '{32'h00000001, 32'h0001FFFF, 32'h12345678, 32'hFFFF0000};
    logic [31:0] vb [4] = '{32'h00000002, 32'h00000001, 32'h11111111, 32'h00010000};
    logic        vs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [34:0] ex;
    int got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge clk);
      if (cyc < 4) begin
        in1 = va[cyc]; in2 = vb[cyc]; sub = vs[cyc]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_in_ready cyc=%0d got %b required 1", cyc, in_ready);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== (cyc >= 1 && cyc <= 4)) begin
        n_bad++;
        $display("FAIL b2b_valid cyc=%0d got %b required %b", cyc, out_valid, (cyc >= 1 && cyc <= 4));
      end
      if (out_valid === 1'b1 && got < 4) begin
        ex = model32(va[got], vb[got], vs[got]);
        n_cmp++;
        if ({cout, ovf, zero, out} !== ex) begin
          n_bad++;
          $display("FAIL b2b_data%0d got %h required %h", got, {cout, ovf, zero, out}, ex);
        end
        $display("b2b%0d: out=%h", got, out);
        got++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] va [8] = '{32'h00000010, 32'h0000FFFF, 32'h80000000, 32'h7FFFFFFF,
                            32'h00000000, 32'hDEADBEEF, 32'h00010000, 32'hFFFFFFFF};
    logic [31:0] vb [8] = '{32'h00000020, 32'h00000001, 32'h80000000, 32'hFFFFFFFF,
                            32'h00000001, 32'h01234567, 32'h00000001, 32'hFFFFFFFF};
    logic        vs [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [34:0] q [$];
    logic [34:0] hold_val;
    bit          held = 1'b0;
    int          sent = 0;
    int          got  = 0;
    for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 8) begin
        in1 = va[sent]; in2 = vb[sent]; sub = vs[sent]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_cmp++;
      if (in_ready !== ~(out_valid & ~out_ready)) begin
        n_bad++;
        $display("FAIL bp_in_ready cyc=%0d got %b required %b", cyc, in_ready, ~(out_valid & ~out_ready));
      end
      if (held) begin
        n_cmp++;
        if (out_valid !== 1'b1 || {cout, ovf, zero, out} !== hold_val) begin
          n_bad++;
          $display("FAIL bp_stable cyc=%0d valid=%b data=%h required 1/%h", cyc, out_valid,
                   {cout, ovf, zero, out}, hold_val);
        end
      end
      held = 1'b0;
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL bp_extra cyc=%0d out=%h required no beat", cyc, out);
        end else if (out_ready) begin
          n_cmp++;
          if ({cout, ovf, zero, out} !== q[0]) begin
            n_bad++;
            $display("FAIL bp_data%0d got %h required %h", got, {cout, ovf, zero, out}, q[0]);
          end
          $display("bp%0d: out=%h c=%b o=%b z=%b", got, out, cout, ovf, zero);
          void'(q.pop_front());
          got++;
        end else begin
          held     = 1'b1;
          hold_val = {cout, ovf, zero, out};
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model32(in1, in2, sub));
        sent++;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (got != 8) begin
      n_bad++;
      $display("FAIL bp_count got %0d beats required 8", got);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    @(negedge clk);
    in1 = 32'h00000100; in2 = 32'h00000200; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in1 = 32'h00000300; in2 = 32'h00000400; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_pre out_valid=%b required 1", out_valid);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 32'd0) begin
      n_bad++;
      $display("FAIL rstmid_drop out_valid=%b in_ready=%b out=%h required 0/1/0", out_valid, in_ready, out);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rstmid_ghost cyc=%0d out_valid=%b out=%h required 0", i, out_valid, out);
      end
    end
    $display("rstmid: in-flight beats discarded, out_valid=%b", out_valid);
  endtask

  task automatic test_wide();
    logic [63:0] va [7];
    logic [63:0] vb [7];
    logic        vs [7];
    logic [63:0] hr [3] = '{64'h0000000100000000, 64'h0000000000000000, 64'h02468ACF13579BCF};
    logic [66:0] ex;
    va[0] = 64'h00000000FFFFFFFF; vb[0] = 64'h1; vs[0] = 1'b0;
    va[1] = 64'hFFFFFFFFFFFFFFFF; vb[1] = 64'h1; vs[1] = 1'b0;
    va[2] = 64'h123456789ABCDEF0; vb[2] = 64'h0FEDCBA987654321; vs[2] = 1'b1;
    for (int i = 3; i < 7; i++) begin
      va[i] = {$urandom, $urandom};
      vb[i] = {$urandom, $urandom};
      vs[i] = 1'(i & 1);
    end
    w_out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ex = model64(va[i], vb[i], vs[i]);
      if (i < 3) ex[63:0] = hr[i];
      @(negedge clk);
      w_in1 = va[i]; w_in2 = vb[i]; w_sub = vs[i]; w_in_valid = 1'b1;
      for (int e = 1; e <= 4; e++) begin
        @(posedge clk); #1;
        if (e < 4) begin
          n_cmp++;
          if (w_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL wide%0d_early edge=%0d out_valid=%b required 0", i, e, w_out_valid);
          end
        end
        @(negedge clk);
        w_in_valid = 1'b0;
        if (e == 4) begin
          n_cmp++;
          if (w_out_valid !== 1'b1 || w_out !== ex[63:0]) begin
            n_bad++;
            $display("FAIL wide%0d_out valid=%b out=%h required 1/%h", i, w_out_valid, w_out, ex[63:0]);
          end
          n_cmp++;
          if ({w_cout, w_ovf, w_zero} !== ex[66:64]) begin
            n_bad++;
            $display("FAIL wide%0d_flags got %b required %b", i, {w_cout, w_ovf, w_zero}, ex[66:64]);
          end
          $display("wide%0d: %h %s %h -> %h", i, va[i], vs[i] ? "-" : "+", vb[i], w_out);
        end
      end
    end
  endtask

  initial begin
    fm = FLAGS;
    rst = 1'b1;
    in_valid = 1'b0; in1 = '0; in2 = '0; sub = 1'b0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in1 = '0; w_in2 = '0; w_sub = 1'b0; w_out_ready = 1'b1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_arith();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
